// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter sitting after the MEM stage.
// It decodes a two-word window (TXDATA at BASE, STATUS at BASE+4), queues
// stored bytes in a small FIFO and serialises them 8N1 on uart_tx.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit (8E1 framing).
module mmio_uart_tx #(
  parameter int          CLOCK_FREQ   = 27000000,
  parameter int          BAUD_RATE    = 115200,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        selected,
  output logic [31:0] output_data,
  output logic        uart_tx
);

  // Cycles per bit, truncated.
  localparam int DIVIDER    = CLOCK_FREQ / BAUD_RATE;
  // A divider of 1 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally.
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  // Occupancy needs one extra bit to represent "full".
  localparam int OCC_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST      = CNT_W'(DIVIDER - 1);
  localparam logic [OCC_W-1:0] OCC_FULL       = OCC_W'(FIFO_DEPTH);
  localparam logic [31:0]      STATUS_ADDRESS = BASE_ADDRESS + 32'd4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t state_reg;
  state_t state_next;

  // Address decode and bus qualifiers.
  logic hit_data;
  logic hit_status;
  logic push_req;
  logic push_ok;
  logic pop;
  logic status_clear;

  // FIFO state.
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_reg;

  // Serialiser datapath.
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             bit_end;
  logic             busy;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg;
`endif

  logic [31:0] status_word;

  // Only the low byte of store data is transmitted.
  logic unused_data_bits;
  assign unused_data_bits = ^input_data[31:8];

  // Window decode; purely combinational so the pipeline never waits.
  assign hit_data     = (address == BASE_ADDRESS);
  assign hit_status   = (address == STATUS_ADDRESS);
  assign selected     = hit_data | hit_status;

  assign fifo_full    = (count_reg == OCC_FULL);
  assign fifo_empty   = (count_reg == '0);

  // A push is judged against the occupancy before this edge, so a pop on
  // the same edge never rescues a push into a full FIFO.
  assign push_req     = mem_write & hit_data;
  assign push_ok      = push_req & ~fifo_full;
  assign pop          = (state_reg == ST_IDLE) & ~fifo_empty;
  assign status_clear = mem_read & hit_status;

  assign bit_end      = (baud_cnt_reg == BAUD_LAST);

  // FIFO storage: write port only, no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= input_data[7:0];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + OCC_W'(1);
        2'b01:   count_reg <= count_reg - OCC_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow wins over a same-edge clear so
  // the event is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (status_clear) begin
      overflow_reg <= 1'b0;
    end
  end

  // STATUS word assembly and read mux; loads see the pre-clear value.
  always_comb begin
    status_word                 = '0;
    status_word[0]              = fifo_full;
    status_word[1]              = fifo_empty;
    status_word[2]              = busy;
    status_word[3]              = overflow_reg;
    status_word[8 +: OCC_W]     = count_reg;
    output_data                 = hit_status ? status_word : 32'h0;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic: every non-idle state lasts whole bit periods.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end && (bit_idx_reg == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: line level and busy, decoded from the current state.
  always_comb begin
    uart_tx = 1'b1;
    busy    = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        uart_tx = 1'b1;
        busy    = 1'b0;
      end
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: uart_tx = parity_reg;
`endif
      ST_STOP:  uart_tx = 1'b1;
      default: begin
        uart_tx = 1'b1;
        busy    = 1'b0;
      end
    endcase
  end

  // Serialiser datapath: baud counter, bit index, shift register and the
  // running parity. The FIFO read is registered straight into shift_reg.
  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else if (state_reg == ST_IDLE) begin
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      if (pop) begin
        shift_reg  <= fifo_mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
        parity_reg <= 1'b0;
`endif
      end
    end else if (bit_end) begin
      baud_cnt_reg <= '0;
      if (state_reg == ST_DATA) begin
        // Accumulate even parity from each bit as it leaves the line.
`ifdef UART_TX_PARITY_EN
        parity_reg  <= parity_reg ^ shift_reg[0];
`endif
        shift_reg   <= {1'b0, shift_reg[7:1]};
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
    end else begin
      baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx at default parameters
// (DIVIDER = 234). Each scenario task drives the bus and checks inline.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int          D    = 234;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STAT = 32'h0000_1004;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic [31:0] address     = 32'h0;
  logic [31:0] input_data  = 32'h0;
  logic        mem_write   = 1'b0;
  logic        mem_read    = 1'b0;
  logic        selected;
  logic [31:0] output_data;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  mmio_uart_tx dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .input_data  (input_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .selected    (selected),
    .output_data (output_data),
    .uart_tx     (uart_tx)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; everything is sampled 1 ns after the rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address    = a;
    input_data = d;
    mem_write  = 1'b1;
    tick();
    mem_write  = 1'b0;
    address    = 32'h0;
    input_data = 32'h0;
  endtask

  // Non-destructive STATUS view: no load strobe, no clock edge.
  task automatic peek_status(output logic [31:0] v);
    address = STAT;
    #1;
    v = output_data;
    address = 32'h0;
  endtask

  // Real load of STATUS: returns the pre-clear value, consumes one edge.
  task automatic load_status(output logic [31:0] v);
    address  = STAT;
    mem_read = 1'b1;
    #1;
    v = output_data;
    tick();
    mem_read = 1'b0;
    address  = 32'h0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Checks every cycle of a frame from position start_t (cycles after the
  // pop edge) to the end; one comparison per line bit.
  task automatic check_frame(input logic [7:0] b, input int start_t);
    logic expv;
    logic seen;
    bit   badbit;
    int   cnt;
    for (int k = 0; k < NB; k++) begin
      expv   = frame_bit(b, k);
      seen   = expv;
      badbit = 0;
      cnt    = 0;
      for (int c = 0; c < D; c++) begin
        if (k * D + c >= start_t) begin
          cnt++;
          if (uart_tx !== expv && !badbit) begin
            badbit = 1;
            seen   = uart_tx;
          end
          tick();
        end
      end
      if (cnt > 0) begin
        total++;
        if (badbit) begin
          bad++;
          $display("FAIL frame_%02h_bit%0d: got %b want %b", b, k, seen, expv);
        end
      end
    end
  endtask

  task automatic check_line_high(input int cycles, input string tag);
    bit badbit = 0;
    for (int i = 0; i < cycles; i++) begin
      if (uart_tx !== 1'b1) badbit = 1;
      tick();
    end
    total++;
    if (badbit) begin
      bad++;
      $display("FAIL %s: line went low or X, want constant 1 for %0d cycles", tag, cycles);
    end
  endtask

  task automatic check_status(input logic [31:0] want, input string tag);
    logic [31:0] v;
    peek_status(v);
    total++;
    if (v !== want) begin
      bad++;
      $display("FAIL %s: status got %08h want %08h", tag, v, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL reset_tx: got %b want 1", uart_tx);
    end
    check_status(32'h0000_0002, "reset_status");
    // Start a frame with a second byte queued, then reset mid data bits.
    store(BASE, 32'h3C);
    store(BASE, 32'hC3);
    repeat (500) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL reset_midframe_tx: got %b want 1", uart_tx);
    end
    check_status(32'h0000_0002, "reset_midframe_status");
    check_line_high(3 * D, "reset_line_quiet");
    $display("test_reset done");
  endtask

  task automatic test_single_byte;
    store(BASE, 32'h0000_00A5);
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL single_edgeN_tx: got %b want 1", uart_tx);
    end
    check_status(32'h0000_0100, "single_queued");
    tick();
    total++;
    if (uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL single_latency: tx got %b want 0 after edge N+1", uart_tx);
    end
    check_status(32'h0000_0006, "single_busy");
    check_frame(8'hA5, 0);
    check_status(32'h0000_0002, "single_done");
    $display("test_single_byte done");
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    // Keep the FSM busy with a leading frame so the FIFO fills before any
    // of the nine bytes can pop.
    store(BASE, 32'hFF);
    tick();
    for (int i = 0; i < 9; i++) store(BASE, i);
    check_status(32'h0000_080D, "ovf_full");
    repeat (NB * D - 9) tick();
    check_status(32'h0000_0809, "ovf_idle_full");
    tick();
    check_status(32'h0000_070C, "ovf_after_pop");
    load_status(v);
    total++;
    if (v[3] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_load1_bit3: got %b want 1", v[3]);
    end
    load_status(v);
    total++;
    if (v !== 32'h0000_0704) begin
      bad++;
      $display("FAIL ovf_load2: got %08h want 00000704", v);
    end
    check_frame(8'h00, 2);
    for (int b = 1; b < 8; b++) begin
      tick();
      check_frame(8'(b), 0);
    end
    check_status(32'h0000_0002, "ovf_drained");
    check_line_high(2 * NB * D, "ovf_no_ninth_byte");
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back;
    store(BASE, 32'h55);
    store(BASE, 32'hAA);
    check_frame(8'h55, 0);
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle_tx: got %b want 1", uart_tx);
    end
    check_status(32'h0000_0100, "b2b_idle_status");
    tick();
    check_frame(8'hAA, 0);
    check_status(32'h0000_0002, "b2b_done");
    $display("test_back_to_back done");
  endtask

  task automatic test_decode;
    address = 32'h0000_1008;
    mem_read = 1'b1;
    #1;
    total++;
    if (selected !== 1'b0 || output_data !== 32'h0) begin
      bad++;
      $display("FAIL decode_1008: sel %b data %08h want 0 00000000", selected, output_data);
    end
    mem_read = 1'b0;
    address  = 32'h0;
    store(STAT, 32'h11);
    store(32'h0000_1008, 32'h22);
    address  = BASE;
    mem_read = 1'b1;
    #1;
    total++;
    if (output_data !== 32'h0 || selected !== 1'b1) begin
      bad++;
      $display("FAIL decode_read_base: data %08h sel %b want 00000000 1", output_data, selected);
    end
    tick();
    mem_read = 1'b0;
    address  = 32'h0;
    check_status(32'h0000_0002, "decode_fifo_unchanged");
    check_line_high(4, "decode_line_quiet");
    $display("test_decode done");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    store(BASE, 32'h07);
    tick();
    check_frame(8'h07, 0);
    check_status(32'h0000_0002, "parity_done");
    $display("test_parity done");
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_back_to_back();
    test_decode();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
